// File: rtl/nco_clock_bank.sv
// Multi-channel phase-accumulator clock generator with deferred, wrap-aligned increment updates.
// Optional quadrature outputs (clk_q) are built when NCO_QUAD_EN is defined.
module nco_clock_bank #(
    parameter int                          CHANNELS  = 4,
    parameter int                          ACC_W     = 16,
    parameter int                          CH_W      = 2,
    parameter logic [CHANNELS*ACC_W-1:0]   RESET_INC = '0,
    parameter logic [CHANNELS-1:0]         RESET_EN  = '1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CH_W-1:0]       cfg_chan,
    input  logic [1:0]            cfg_field,
    input  logic [ACC_W-1:0]      cfg_data,
    output logic [CHANNELS-1:0]   clk_out,
    output logic [CHANNELS-1:0]   tick
`ifdef NCO_QUAD_EN
    ,
    output logic [CHANNELS-1:0]   clk_q
`endif
);

    localparam logic [CH_W:0] CH_LIMIT  = (CH_W+1)'(CHANNELS);
    localparam logic [1:0]    FIELD_INC = 2'd0;
    localparam logic [1:0]    FIELD_PHS = 2'd1;
    localparam logic [1:0]    FIELD_EN  = 2'd2;

    logic [ACC_W-1:0]    acc_q      [CHANNELS];
    logic [ACC_W-1:0]    acc_d      [CHANNELS];
    logic [ACC_W-1:0]    inc_q      [CHANNELS];
    logic [ACC_W-1:0]    inc_d      [CHANNELS];
    logic [ACC_W-1:0]    pend_inc_q [CHANNELS];
    logic [ACC_W-1:0]    pend_inc_d [CHANNELS];
    logic [ACC_W:0]      sum        [CHANNELS];
    logic [CHANNELS-1:0] pend_q, pend_d;
    logic [CHANNELS-1:0] en_q, en_d;
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic [CHANNELS-1:0] hit, carry, load;
    logic                sel_pend;
    logic                chan_ok;
    logic                accept;

    // Handshake: a config write transfers on a rising clk edge where cfg_valid and
    // cfg_ready are both high; cfg_ready depends only on cfg_chan and that channel's
    // pending flag, never on cfg_valid, and out-of-range channels are never ready.
    always_comb begin
        sel_pend = 1'b0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (cfg_chan == CH_W'(ch)) begin
                sel_pend = pend_q[ch];
            end
        end
        chan_ok   = ({1'b0, cfg_chan} < CH_LIMIT);
        cfg_ready = chan_ok & ~sel_pend;
        accept    = cfg_valid & cfg_ready;
    end

    always_comb begin
        hit    = '0;
        carry  = '0;
        load   = '0;
        pend_d = pend_q;
        en_d   = en_q;
        tick_d = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            acc_d[ch]      = acc_q[ch];
            inc_d[ch]      = inc_q[ch];
            pend_inc_d[ch] = pend_inc_q[ch];
            sum[ch]        = {1'b0, acc_q[ch]} + {1'b0, inc_q[ch]};

            hit[ch]   = accept && (cfg_chan == CH_W'(ch));
            carry[ch] = en_q[ch] & sum[ch][ACC_W];
            load[ch]  = hit[ch] && (cfg_field == FIELD_PHS);

            // A phase load overrides the add but the add's carry still retires a pending increment.
            if (load[ch]) begin
                acc_d[ch] = cfg_data;
            end else if (en_q[ch]) begin
                acc_d[ch] = sum[ch][ACC_W-1:0];
            end
            tick_d[ch] = carry[ch] & ~load[ch];

            if (pend_q[ch] && (carry[ch] || !en_q[ch])) begin
                inc_d[ch]  = pend_inc_q[ch];
                pend_d[ch] = 1'b0;
            end

            // Increment writes cannot coincide with the retire above: ready is low while pending.
            if (hit[ch] && (cfg_field == FIELD_INC)) begin
                pend_inc_d[ch] = cfg_data;
                pend_d[ch]     = 1'b1;
            end
            if (hit[ch] && (cfg_field == FIELD_EN)) begin
                en_d[ch] = cfg_data[0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                acc_q[ch]      <= '0;
                inc_q[ch]      <= RESET_INC[ch*ACC_W +: ACC_W];
                pend_inc_q[ch] <= '0;
            end
            pend_q <= '0;
            en_q   <= RESET_EN;
            tick_q <= '0;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                acc_q[ch]      <= acc_d[ch];
                inc_q[ch]      <= inc_d[ch];
                pend_inc_q[ch] <= pend_inc_d[ch];
            end
            pend_q <= pend_d;
            en_q   <= en_d;
            tick_q <= tick_d;
        end
    end

    always_comb begin
        clk_out = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            clk_out[ch] = acc_q[ch][ACC_W-1];
        end
    end

    assign tick = tick_q;

`ifdef NCO_QUAD_EN
    localparam logic [ACC_W-1:0] QUARTER = {2'b01, {(ACC_W-2){1'b0}}};

    logic [ACC_W-1:0]    qsum [CHANNELS];
    logic [CHANNELS-1:0] clkq_q, clkq_d;

    // Registered from the next accumulator value so clk_q lines up with clk_out.
    always_comb begin
        clkq_d = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            qsum[ch]   = acc_d[ch] + QUARTER;
            clkq_d[ch] = qsum[ch][ACC_W-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clkq_q <= '0;
        end else begin
            clkq_q <= clkq_d;
        end
    end

    assign clk_q = clkq_q;
`endif

endmodule

// File: tb/tb_nco_clock_bank.sv
// Bench for nco_clock_bank: reset table, hand-written corner sequences and randomized
// config traffic, all checked against an arithmetic reference model.
module tb_nco_clock_bank;

    localparam int CHN = 4;
    localparam int AW  = 16;
    localparam int CW  = 3;
    localparam logic [CHN*AW-1:0] R_INC = {16'd0, 16'd2048, 16'd4096, 16'd16384};
    localparam int unsigned MODV = 65536;

    logic            clk = 1'b0;
    logic            reset;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [CW-1:0]   cfg_chan;
    logic [1:0]      cfg_field;
    logic [AW-1:0]   cfg_data;
    logic [CHN-1:0]  clk_out;
    logic [CHN-1:0]  tick;
`ifdef NCO_QUAD_EN
    logic [CHN-1:0]  clk_q;
`endif

    nco_clock_bank #(
        .CHANNELS (CHN),
        .ACC_W    (AW),
        .CH_W     (CW),
        .RESET_INC(R_INC),
        .RESET_EN (4'b1111)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_chan (cfg_chan),
        .cfg_field(cfg_field),
        .cfg_data (cfg_data),
        .clk_out  (clk_out),
        .tick     (tick)
`ifdef NCO_QUAD_EN
        ,
        .clk_q    (clk_q)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model
    int unsigned m_acc  [CHN];
    int unsigned m_inc  [CHN];
    int unsigned m_pinc [CHN];
    bit          m_pend [CHN];
    bit          m_en   [CHN];
    bit          m_tick [CHN];

    logic [11:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic        last_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready(input int ch);
        return (ch < CHN) && !m_pend[ch];
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < CHN; ch++) begin
            m_acc[ch]  = 0;
            m_inc[ch]  = R_INC[ch*AW +: AW];
            m_pinc[ch] = 0;
            m_pend[ch] = 0;
            m_en[ch]   = 1;
            m_tick[ch] = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_step();
        bit took;
        took = cfg_valid && model_ready(int'(cfg_chan));
        for (int ch = 0; ch < CHN; ch++) begin
            int unsigned s;
            bit hit, cy, ld;
            s   = m_acc[ch] + m_inc[ch];
            cy  = m_en[ch] && (s >= MODV);
            hit = took && (int'(cfg_chan) == ch);
            ld  = hit && (cfg_field == 2'd1);
            m_tick[ch] = cy && !ld;
            if (ld) m_acc[ch] = cfg_data;
            else if (m_en[ch]) m_acc[ch] = s % MODV;
            if (m_pend[ch] && (cy || !m_en[ch])) begin
                m_inc[ch]  = m_pinc[ch];
                m_pend[ch] = 0;
            end
            if (hit && cfg_field == 2'd0) begin
                m_pinc[ch] = cfg_data;
                m_pend[ch] = 1;
            end
            if (hit && cfg_field == 2'd2) m_en[ch] = cfg_data[0];
        end
    endtask

    function automatic logic [11:0] exp_word();
        logic [11:0] w;
        w = '0;
        for (int ch = 0; ch < CHN; ch++) begin
            w[ch]     = (m_acc[ch] >= 32768);
            w[4 + ch] = m_tick[ch];
            w[8 + ch] = (((m_acc[ch] + 16384) % MODV) >= 32768);
        end
        return w;
    endfunction

    // driver tasks
    task automatic step();
        logic [11:0] e;
        #1;
        last_ready = cfg_ready;
        chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, model_ready(int'(cfg_chan))});
        @(posedge clk);
        model_step();
        exp_q.push_back(exp_word());
        #1;
        e = exp_q.pop_front();
        chk("clk_out", {28'd0, clk_out}, {28'd0, e[3:0]});
        chk("tick", {28'd0, tick}, {28'd0, e[7:4]});
`ifdef NCO_QUAD_EN
        chk("clk_q", {28'd0, clk_q}, {28'd0, e[11:8]});
`endif
    endtask

    task automatic cfg_write(input int ch, input int f, input int d);
        bit ok, r;
        ok        = 0;
        cfg_valid = 1'b1;
        cfg_chan  = CW'(ch);
        cfg_field = 2'(f);
        cfg_data  = AW'(d);
        for (int i = 0; i < 64; i++) begin
            r = model_ready(ch);
            step();
            if (r) begin
                ok = 1;
                break;
            end
        end
        cfg_valid = 1'b0;
        chk("cfg_write_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_tick(input int ch, input int maxc, input int exp_n, input string name);
        int n;
        n = 0;
        for (int i = 0; i < maxc; i++) begin
            step();
            n++;
            if (tick[ch] === 1'b1) break;
        end
        chk(name, n, exp_n);
    endtask

    typedef struct {
        logic [CW-1:0] chan;
        logic          exp_ready;
        logic [3:0]    exp_out;
        logic [3:0]    exp_tick;
    } tv_t;

    tv_t tv [12];

    initial begin
        tv[0]  = '{3'd0, 1'b1, 4'b0000, 4'b0000};
        tv[1]  = '{3'd1, 1'b1, 4'b0001, 4'b0000};
        tv[2]  = '{3'd2, 1'b1, 4'b0001, 4'b0000};
        tv[3]  = '{3'd3, 1'b1, 4'b0000, 4'b0001};
        tv[4]  = '{3'd0, 1'b1, 4'b0000, 4'b0000};
        tv[5]  = '{3'd1, 1'b1, 4'b0001, 4'b0000};
        tv[6]  = '{3'd4, 1'b0, 4'b0001, 4'b0000};
        tv[7]  = '{3'd0, 1'b1, 4'b0010, 4'b0001};
        tv[8]  = '{3'd2, 1'b1, 4'b0010, 4'b0000};
        tv[9]  = '{3'd3, 1'b1, 4'b0011, 4'b0000};
        tv[10] = '{3'd7, 1'b0, 4'b0011, 4'b0000};
        tv[11] = '{3'd0, 1'b1, 4'b0010, 4'b0001};

        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_chan  = '0;
        cfg_field = '0;
        cfg_data  = '0;
        model_reset();
        #23;
        chk("reset_clk_out", {28'd0, clk_out}, 32'd0);
        chk("reset_tick", {28'd0, tick}, 32'd0);
        chk("reset_ready", {31'd0, cfg_ready}, 32'd1);
        reset = 1'b0;

        // free run from reset, table-driven
        for (int k = 0; k < 12; k++) begin
            cfg_chan = tv[k].chan;
            step();
            chk($sformatf("tv%0d_ready", k), {31'd0, last_ready}, {31'd0, tv[k].exp_ready});
            chk($sformatf("tv%0d_out", k), {28'd0, clk_out}, {28'd0, tv[k].exp_out});
            chk($sformatf("tv%0d_tick", k), {28'd0, tick}, {28'd0, tv[k].exp_tick});
        end

        // increment change mid-period on ch0 (acc0 = 16384 at the accept edge)
        cfg_chan = 3'd0;
        step();
        cfg_write(0, 0, 8192);
        chk("ch0_pend_ready_low", {31'd0, cfg_ready}, 32'd0);
        wait_tick(0, 10, 2, "ch0_old_period_end");
        chk("ch0_ready_after_wrap", {31'd0, cfg_ready}, 32'd1);
        wait_tick(0, 16, 8, "ch0_new_period");

        // phase load on ch1 from the low half
        cfg_chan = 3'd1;
        wait_tick(1, 20, 8, "ch1_natural_wrap");
        chk("ch1_low_before_load", {31'd0, clk_out[1]}, 32'd0);
        cfg_write(1, 1, 32768);
        chk("ch1_high_after_load", {31'd0, clk_out[1]}, 32'd1);
        chk("ch1_no_tick_on_load", {31'd0, tick[1]}, 32'd0);
        wait_tick(1, 16, 8, "ch1_tick_after_load");

        // disable ch2, increment applies on next edge, re-enable
        cfg_write(2, 2, 0);
        cfg_chan = 3'd2;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("ch2_disabled_tick", {31'd0, tick[2]}, 32'd0);
        end
        cfg_write(2, 0, 1000);
        chk("ch2_pend_ready_low", {31'd0, cfg_ready}, 32'd0);
        step();
        chk("ch2_inc_applied_ready", {31'd0, cfg_ready}, 32'd1);
        cfg_write(2, 2, 1);
        for (int i = 0; i < 6; i++) step();

        // inc = 0 on ch3 kept it frozen; switch it to half scale
        chk("ch3_frozen_out", {31'd0, clk_out[3]}, 32'd0);
        cfg_write(3, 2, 0);
        cfg_write(3, 0, 32768);
        step();
        cfg_write(3, 2, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("ch3_half_out", {31'd0, clk_out[3]}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("ch3_half_tick", {31'd0, tick[3]}, (i % 2 == 1) ? 32'd1 : 32'd0);
        end

        // out-of-range channel stalls the writer
        cfg_valid = 1'b1;
        cfg_chan  = 3'd4;
        cfg_field = 2'd1;
        cfg_data  = 16'd1234;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("oor_ready_low", {31'd0, last_ready}, 32'd0);
        end
        cfg_write(3, 1, 1234);

        // asynchronous reset with a pending increment on ch1
        cfg_write(1, 0, 999);
        cfg_chan = 3'd1;
        step();
        step();
        chk("ch1_pend_before_reset", {31'd0, cfg_ready}, 32'd0);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset_out", {28'd0, clk_out}, 32'd0);
        chk("async_reset_tick", {28'd0, tick}, 32'd0);
        chk("async_reset_ready", {31'd0, cfg_ready}, 32'd1);
`ifdef NCO_QUAD_EN
        chk("async_reset_clk_q", {28'd0, clk_q}, 32'd0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_hold_out", {28'd0, clk_out}, 32'd0);
        #2;
        reset = 1'b0;
        cfg_chan = 3'd0;
        wait_tick(0, 10, 4, "post_reset_ch0_period");

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int sel;
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_chan  = CW'($urandom_range(0, 4));
            cfg_field = 2'($urandom_range(0, 3));
            sel       = $urandom_range(0, 3);
            case (sel)
                0:       cfg_data = 16'd32768;
                1:       cfg_data = 16'($urandom_range(1, 40) * 256);
                2:       cfg_data = 16'($urandom_range(0, 1));
                default: cfg_data = 16'($urandom);
            endcase
            step();
        end
        cfg_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
